br_output_checker: RTL

Testbench-side sequencer for the branch golden-output memory (16-bit address, 8-bit combinational read). It walks the memory from a programmed base address and compares each byte against the DUT's output stream, accepted over a valid/ready handshake. It counts mismatches against a signed tolerance, captures the first failure, and runs a stall watchdog. It sits between the branch DUT output port and the golden memory and drives the bench's pass/fail.

---
 rtl/br_output_checker_if.sv | 15 +
 rtl/br_output_checker.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/br_output_checker_if.sv
// Golden-memory read port plus the DUT output-byte handshake, seen from the checker.
// master = checker side, slave = golden memory / DUT side.
interface br_output_checker_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              dut_valid;
  logic [DATA_W-1:0] dut_data;
  logic              dut_ready;

  modport master (output mem_addr, dut_ready, input mem_data, dut_valid, dut_data);
  modport slave  (input mem_addr, dut_ready, output mem_data, dut_valid, dut_data);
endinterface

// File: rtl/br_output_checker.sv
// Walks the golden memory from base_addr and compares it byte-for-byte with the DUT
// output stream; counts mismatches beyond TOL, captures the first one, and aborts on a stall.
module br_output_checker #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int TOL     = 0,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [ADDR_W-1:0]      len,
  br_output_checker_if.master    bus,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   timeout,
  output logic [15:0]            err_count,
  output logic [ADDR_W-1:0]      first_err_addr,
  output logic [DATA_W-1:0]      first_err_exp,
  output logic [DATA_W-1:0]      first_err_got
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam int WD_W = $clog2(TIMEOUT) + 1;
  localparam int DW1  = DATA_W + 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);
  localparam logic [DW1-1:0]  TOL_V  = DW1'(TOL);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [15:0]       err_q, err_d;
  logic [ADDR_W-1:0] fea_q, fea_d;
  logic [DATA_W-1:0] fee_q, fee_d;
  logic [DATA_W-1:0] feg_q, feg_d;
  logic              timeout_q, timeout_d;
  logic              pass_q, pass_d;

  logic              beat;
  logic              mismatch;
  logic signed [DW1-1:0] diff;
  logic [DW1-1:0]    mag;

  assign beat = bus.dut_valid && (state_q == S_RUN);

  // One extra bit keeps the full -255..+255 difference of two signed bytes exact.
  assign diff = $signed({bus.dut_data[DATA_W-1], bus.dut_data})
              - $signed({bus.mem_data[DATA_W-1], bus.mem_data});
  assign mag      = diff[DW1-1] ? DW1'(-diff) : DW1'(diff);
  assign mismatch = mag > TOL_V;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      mem_addr_q  <= '0;
      remaining_q <= '0;
      wd_q        <= '0;
      err_q       <= '0;
      fea_q       <= '0;
      fee_q       <= '0;
      feg_q       <= '0;
      timeout_q   <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      remaining_q <= remaining_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
      fea_q       <= fea_d;
      fee_q       <= fee_d;
      feg_q       <= feg_d;
      timeout_q   <= timeout_d;
      pass_q      <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = (len == '0) ? S_DONE : S_RUN;
      S_RUN: begin
        if (beat && remaining_q == ADDR_W'(1))  state_d = S_DONE;
        else if (!beat && wd_q == WD_MAX)       state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_addr_d  = mem_addr_q;
    remaining_d = remaining_q;
    wd_d        = wd_q;
    err_d       = err_q;
    fea_d       = fea_q;
    fee_d       = fee_q;
    feg_d       = feg_q;
    timeout_d   = timeout_q;
    pass_d      = pass_q;
    if (state_q != S_RUN) begin
      if (start) begin
        mem_addr_d  = base_addr;
        remaining_d = len;
        wd_d        = '0;
        err_d       = '0;
        fea_d       = '0;
        fee_d       = '0;
        feg_d       = '0;
        timeout_d   = 1'b0;
        pass_d      = (len == '0);
      end
    end else begin
      if (beat) begin
        mem_addr_d  = mem_addr_q + ADDR_W'(1);
        remaining_d = remaining_q - ADDR_W'(1);
        wd_d        = '0;
        if (mismatch) begin
          if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          // Saturation never returns to zero, so zero still means "no mismatch yet".
          if (err_q == 16'd0) begin
            fea_d = mem_addr_q;
            fee_d = bus.mem_data;
            feg_d = bus.dut_data;
          end
        end
      end else begin
        wd_d = wd_q + WD_W'(1);
        if (wd_q == WD_MAX) timeout_d = 1'b1;
      end
      if (state_d == S_DONE) pass_d = (err_d == 16'd0) && !timeout_d;
    end
  end

  always_comb begin
    busy          = (state_q == S_RUN);
    done          = (state_q == S_DONE);
    bus.dut_ready = (state_q == S_RUN);
  end

  assign bus.mem_addr    = mem_addr_q;
  assign pass            = pass_q;
  assign timeout         = timeout_q;
  assign err_count       = err_q;
  assign first_err_addr  = fea_q;
  assign first_err_exp   = fee_q;
  assign first_err_got   = feg_q;

endmodule
